// File: rtl/pe_ifetch_pkg.sv
// pe_ifetch_pkg: shared definitions for the PE instruction-fetch stage.
//   - Default PE instruction width and instruction-memory address width.
//   - Bit positions of the 2-bit data-select and 2-bit predication fields
//     that sit above the raw instruction in every fetched word.
//   - fetch_action_e and pe_fetch_action(): the per-edge decision the fetch
//     stage makes. It is kept here so the priority order is written once.
package pe_ifetch_pkg;

  localparam int DEF_PE_INS_WIDTH        = 32;
  localparam int DEF_PE_I_MEM_ADDR_WIDTH = 13;

  // Fetched word layout: {pred[1:0], dsel[1:0], instr[INS_WIDTH-1:0]}
  localparam int DEF_PE_DSEL_LSB = DEF_PE_INS_WIDTH;
  localparam int DEF_PE_PRED_LSB = DEF_PE_INS_WIDTH + 2;

  typedef enum logic [1:0] {
    FA_REDIRECT,
    FA_FREEZE,
    FA_IDLE,
    FA_ADVANCE
  } fetch_action_e;

  // The checks are ordered by priority: a redirect beats any freeze, and a
  // freeze only happens when something is actually sitting on the output.
  function automatic fetch_action_e pe_fetch_action(input logic branch,
                                                    input logic stall_int,
                                                    input logic enable,
                                                    input logic out_valid);
    fetch_action_e act;
    if (branch)                        act = FA_REDIRECT;
    else if (stall_int && out_valid)   act = FA_FREEZE;
    else if (!enable)                  act = FA_IDLE;
    else                               act = FA_ADVANCE;
    return act;
  endfunction

endpackage

// File: rtl/pe_ifetch.sv
// pe_ifetch: PE instruction-fetch stage.
// The stage drives the word address of a synchronous instruction memory,
// which returns data one cycle after the address. It tracks which memory
// words are real in-order fetches. It keeps a one-entry skid buffer so a
// word is never lost while decode stalls. Branch redirects are applied here.
//
// Ports:
//   iClk, iReset_n          clock; synchronous active-low reset
//   iEnable                 run enable (low freezes fetch, masks valid)
//   oIF_IMEM_Addr           word address to instruction memory (= PC reg)
//   iIMEM_IF_Instruction    memory read data, one cycle after the address
//   oIF_ID_Valid            instruction/PC outputs valid
//   oIF_ID_Instruction      fetched word {pred, dsel, instr}
//   oIF_ID_PC               address of oIF_ID_Instruction
//   iID_IF_Stall            decode not accepting this cycle
//   iID_IF_Branch_Valid     redirect request
//   iID_IF_Branch_Target    redirect word address
//   oIF_Fetch_Count         (PE_IF_PERF_CNT_EN only) saturating transfer count
//   oIF_Stall_Count         (PE_IF_PERF_CNT_EN only) saturating stalled-valid count
//
// Build option: define PE_IF_PERF_CNT_EN to add the two performance counters.
module pe_ifetch
  import pe_ifetch_pkg::*;
#(
  parameter int                    INS_WIDTH  = DEF_PE_INS_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_PE_I_MEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iEnable,
  output logic [ADDR_WIDTH-1:0] oIF_IMEM_Addr,
  input  logic [INS_WIDTH+3:0]  iIMEM_IF_Instruction,
  output logic                  oIF_ID_Valid,
  output logic [INS_WIDTH+3:0]  oIF_ID_Instruction,
  output logic [ADDR_WIDTH-1:0] oIF_ID_PC,
  input  logic                  iID_IF_Stall,
  input  logic                  iID_IF_Branch_Valid,
  input  logic [ADDR_WIDTH-1:0] iID_IF_Branch_Target
`ifdef PE_IF_PERF_CNT_EN
  ,
  output logic [31:0]           oIF_Fetch_Count,
  output logic [31:0]           oIF_Stall_Count
`endif
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  iss_valid_q, iss_valid_d;
  logic [ADDR_WIDTH-1:0] iss_pc_q, iss_pc_d;
  logic [INS_WIDTH+3:0]  hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                  hold_valid_q, hold_valid_d;

  logic          out_valid;
  logic          stall_int;
  fetch_action_e action;

  // The skid entry, when valid, is always older than whatever the memory is
  // showing, so it takes precedence on the output.
  always_comb begin
    out_valid = hold_valid_q | iss_valid_q;
    stall_int = iID_IF_Stall | ~iEnable;
    action    = pe_fetch_action(iID_IF_Branch_Valid, stall_int, iEnable, out_valid);
  end

  // While frozen the PC does not move. The memory therefore keeps returning
  // the word after the held one. That word is marked not-issued and is
  // simply read again once the freeze releases.
  always_comb begin
    pc_d         = pc_q;
    iss_valid_d  = iss_valid_q;
    iss_pc_d     = iss_pc_q;
    hold_d       = hold_q;
    hold_pc_d    = hold_pc_q;
    hold_valid_d = hold_valid_q;
    unique case (action)
      FA_REDIRECT: begin
        pc_d         = iID_IF_Branch_Target;
        iss_valid_d  = 1'b0;
        hold_valid_d = 1'b0;
      end
      FA_FREEZE: begin
        if (!hold_valid_q) begin
          hold_d       = iIMEM_IF_Instruction;
          hold_pc_d    = iss_pc_q;
          hold_valid_d = 1'b1;
        end
        iss_valid_d = 1'b0;
      end
      FA_IDLE: begin
        iss_valid_d = 1'b0;
      end
      default: begin
        pc_d         = pc_q + 1'b1;
        iss_pc_d     = pc_q;
        iss_valid_d  = 1'b1;
        hold_valid_d = 1'b0;
      end
    endcase
  end

  // The data and PC registers are also cleared, so the don't-care outputs
  // after reset are driven by defined values.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      pc_q         <= RESET_PC;
      iss_valid_q  <= 1'b0;
      iss_pc_q     <= RESET_PC;
      hold_q       <= '0;
      hold_pc_q    <= RESET_PC;
      hold_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      iss_valid_q  <= iss_valid_d;
      iss_pc_q     <= iss_pc_d;
      hold_q       <= hold_d;
      hold_pc_q    <= hold_pc_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign oIF_IMEM_Addr      = pc_q;
  assign oIF_ID_Valid       = out_valid & iEnable;
  assign oIF_ID_Instruction = hold_valid_q ? hold_q : iIMEM_IF_Instruction;
  assign oIF_ID_PC          = hold_valid_q ? hold_pc_q : iss_pc_q;

`ifdef PE_IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Both counters stop at all-ones rather than wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (oIF_ID_Valid && !iID_IF_Stall && (fetch_cnt_q != '1))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (oIF_ID_Valid && iID_IF_Stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oIF_Fetch_Count = fetch_cnt_q;
  assign oIF_Stall_Count = stall_cnt_q;
`endif

endmodule
